// File: rtl/vis_collect.sv
// vis_collect -- collects completed visibilities from an accumulator and
// streams them out as framed AXI-Stream words.
//
// Each completed visibility (valid_i && last_i) is packed as {im, re} and
// pushed into a DEPTH-word FIFO. The upstream has no backpressure, so a word
// that arrives while the FIFO is full is dropped. Drops are recorded in a
// sticky flag and in a saturating counter. The head of the FIFO is presented
// from registered outputs. m_tlast marks every FRAME-th delivered word.
//
// Ports:
//   clock_i    : sole clock, rising edge
//   reset_i    : synchronous active-high reset
//   valid_i    : accumulator word strobe
//   last_i     : qualifies valid_i as a completed accumulation
//   re_i, im_i : visibility components (OBITS each)
//   m_tvalid   : output word available (registered)
//   m_tready   : downstream accept
//   m_tlast    : final word of an output frame (registered)
//   m_tdata    : {im, re}, re in the LSBs (registered)
//   level_o    : stored words, including the one on m_tdata (0..DEPTH)
//   overflow_o : sticky, at least one word dropped
//   drops_o    : saturating count of dropped words
module vis_collect #(
    parameter int OBITS = 7,
    parameter int DEPTH = 16,
    parameter int FRAME = 8
) (
    input  logic                     clock_i,
    input  logic                     reset_i,
    input  logic                     valid_i,
    input  logic                     last_i,
    input  logic [OBITS-1:0]         re_i,
    input  logic [OBITS-1:0]         im_i,
    output logic                     m_tvalid,
    input  logic                     m_tready,
    output logic                     m_tlast,
    output logic [2*OBITS-1:0]       m_tdata,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     overflow_o,
    output logic [7:0]               drops_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int FW = (FRAME > 1) ? $clog2(FRAME) : 1;
    localparam int WW = 2 * OBITS;

    localparam logic [LW-1:0] DEPTH_L    = LW'(DEPTH);
    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME - 1);

    // Storage and state
    logic [WW-1:0] mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [LW-1:0] level_r;
    logic [FW-1:0] frame_r;
    logic          tvalid_r;
    logic          tlast_r;
    logic [WW-1:0] tdata_r;
    logic          overflow_r;
    logic [7:0]    drops_r;

    // Next-state terms
    logic          full_s;
    logic          attempt_s;
    logic          wr_s;
    logic          drop_s;
    logic          pop_s;
    logic [WW-1:0] word_s;
    logic [LW-1:0] level_nxt_s;
    logic [FW-1:0] frame_nxt_s;
    logic [WW-1:0] head_nxt_s;

    // Write/pop decisions; fullness uses start-of-cycle state only, so a
    // pop in the same cycle never makes room for that cycle's write.
    always_comb begin
        full_s    = (level_r == DEPTH_L);
        attempt_s = valid_i && last_i;
        wr_s      = attempt_s && !full_s;
        drop_s    = attempt_s && full_s;
        pop_s     = tvalid_r && m_tready;
        word_s    = {im_i, re_i};
    end

    // Occupancy after this cycle's push/pop
    always_comb begin
        level_nxt_s = level_r;
        case ({wr_s, pop_s})
            2'b10:   level_nxt_s = level_r + LW'(1);
            2'b01:   level_nxt_s = level_r - LW'(1);
            default: level_nxt_s = level_r;
        endcase
    end

    // Frame index of the word that will be presented next
    always_comb begin
        frame_nxt_s = frame_r;
        if (pop_s) begin
            if (frame_r == FRAME_LAST) begin
                frame_nxt_s = '0;
            end else begin
                frame_nxt_s = frame_r + FW'(1);
            end
        end else begin
            frame_nxt_s = frame_r;
        end
    end

    // Next head word: the stored successor when one exists, otherwise the
    // word being written this cycle (which lands behind an emptied FIFO).
    always_comb begin
        head_nxt_s = tdata_r;
        if (pop_s) begin
            if (level_r > LW'(1)) begin
                head_nxt_s = mem_r[rd_ptr_r + AW'(1)];
            end else begin
                head_nxt_s = word_s;
            end
        end else if (!tvalid_r) begin
            head_nxt_s = word_s;
        end else begin
            head_nxt_s = tdata_r;
        end
    end

    // FIFO storage; the head slot stays occupied until it is popped
    always_ff @(posedge clock_i) begin
        if (!reset_i && wr_s) begin
            mem_r[wr_ptr_r] <= word_s;
        end
    end

    // Pointers, occupancy, framing, output registers and drop accounting
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            level_r    <= '0;
            frame_r    <= '0;
            tvalid_r   <= 1'b0;
            tlast_r    <= 1'b0;
            tdata_r    <= '0;
            overflow_r <= 1'b0;
            drops_r    <= 8'd0;
        end else begin
            if (wr_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            level_r  <= level_nxt_s;
            frame_r  <= frame_nxt_s;
            tvalid_r <= (level_nxt_s != '0);
            tlast_r  <= (level_nxt_s != '0) && (frame_nxt_s == FRAME_LAST);
            tdata_r  <= head_nxt_s;
            if (drop_s) begin
                overflow_r <= 1'b1;
                if (drops_r != 8'hFF) begin
                    drops_r <= drops_r + 8'd1;
                end
            end
        end
    end

    assign m_tvalid   = tvalid_r;
    assign m_tlast    = tlast_r;
    assign m_tdata    = tdata_r;
    assign level_o    = level_r;
    assign overflow_o = overflow_r;
    assign drops_o    = drops_r;

endmodule

// File: tb/tb_vis_collect.sv
// Testbench for vis_collect (DEPTH=4, FRAME=3, OBITS=7). A queue-based
// reference model tracks stored words, delivered-word count and drops; every
// cycle the DUT outputs are compared against it, plus directed scenario checks.
module tb_vis_collect;

    localparam int OBITS = 7;
    localparam int DEPTH = 4;
    localparam int FRAME = 3;

    logic               clock_i;
    logic               reset_i;
    logic               valid_i;
    logic               last_i;
    logic [OBITS-1:0]   re_i;
    logic [OBITS-1:0]   im_i;
    logic               m_tvalid;
    logic               m_tready;
    logic               m_tlast;
    logic [2*OBITS-1:0] m_tdata;
    logic [2:0]         level_o;
    logic               overflow_o;
    logic [7:0]         drops_o;

    vis_collect #(.OBITS(OBITS), .DEPTH(DEPTH), .FRAME(FRAME)) dut (
        .clock_i    (clock_i),
        .reset_i    (reset_i),
        .valid_i    (valid_i),
        .last_i     (last_i),
        .re_i       (re_i),
        .im_i       (im_i),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .m_tlast    (m_tlast),
        .m_tdata    (m_tdata),
        .level_o    (level_o),
        .overflow_o (overflow_o),
        .drops_o    (drops_o)
    );

    initial clock_i = 1'b0;
    always #5 clock_i = ~clock_i;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [13:0] q_m[$];
    int          delivered_m = 0;
    int          drops_m     = 0;
    bit          ovf_m       = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, advance the model, compare after the edge.
    task automatic step(input bit v, input bit l, input logic [6:0] re, input logic [6:0] im,
                        input bit rdy, input bit rst);
        bit full;
        bit popped;
        valid_i  = v;
        last_i   = l;
        re_i     = re;
        im_i     = im;
        m_tready = rdy;
        reset_i  = rst;
        if (rst) begin
            q_m.delete();
            delivered_m = 0;
            drops_m     = 0;
            ovf_m       = 1'b0;
        end else begin
            full   = (q_m.size() == DEPTH);
            popped = (q_m.size() > 0) && rdy;
            if (v && l) begin
                if (full) begin
                    ovf_m   = 1'b1;
                    drops_m = (drops_m < 255) ? drops_m + 1 : 255;
                end else begin
                    q_m.push_back({im, re});
                end
            end
            if (popped) begin
                void'(q_m.pop_front());
                delivered_m++;
            end
        end
        @(posedge clock_i);
        #1;
        check("tvalid", 32'(m_tvalid), 32'(q_m.size() > 0));
        check("level", 32'(level_o), 32'(q_m.size()));
        check("overflow", 32'(overflow_o), 32'(ovf_m));
        check("drops", 32'(drops_o), 32'(drops_m));
        if (q_m.size() > 0) begin
            check("tdata", 32'(m_tdata), 32'(q_m[0]));
            check("tlast", 32'(m_tlast), 32'((delivered_m % FRAME) == FRAME - 1));
        end
    endtask

    initial begin
        int written;
        int cyc;
        bit v;
        bit l;
        bit r;
        valid_i  = 1'b0;
        last_i   = 1'b0;
        re_i     = '0;
        im_i     = '0;
        m_tready = 1'b0;
        reset_i  = 1'b1;

        // Reset state
        step(1'b0, 1'b0, 7'd0, 7'd0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 7'd0, 7'd0, 1'b0, 1'b1);
        check("reset_tlast", 32'(m_tlast), 32'd0);
        step(1'b0, 1'b0, 7'd0, 7'd0, 1'b1, 1'b0);

        // Three words re=1..3, im=-1..-3, ready high
        step(1'b1, 1'b1, 7'd1, 7'h7F, 1'b1, 1'b0);
        check("r032_first_valid", 32'(m_tvalid), 32'd1);
        check("r032_first_data", 32'(m_tdata), 32'h3F81);
        step(1'b1, 1'b1, 7'd2, 7'h7E, 1'b1, 1'b0);
        check("r032_second_data", 32'(m_tdata), 32'h3F02);
        step(1'b1, 1'b1, 7'd3, 7'h7D, 1'b1, 1'b0);
        check("r032_third_data", 32'(m_tdata), 32'h3E83);
        check("r032_third_last", 32'(m_tlast), 32'd1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 7'd0, 7'd0, 1'b1, 1'b0);

        // valid without last is ignored
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 7'(i + 9), 7'(i), 1'(i % 2), 1'b0);
        check("r033_level", 32'(level_o), 32'd0);

        // Six writes with ready low: four stored, two dropped
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 7'(i + 16), 7'(i + 32), 1'b0, 1'b0);
        check("r034_level", 32'(level_o), 32'd4);
        check("r034_overflow", 32'(overflow_o), 32'd1);
        check("r034_drops", 32'(drops_o), 32'd2);
        check("r034_head", 32'(m_tdata), 32'({7'd32, 7'd16}));
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 7'd0, 7'd0, 1'b1, 1'b0);

        // Full FIFO, write and pop in the same cycle: write is dropped
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 7'(i + 40), 7'(i + 50), 1'b0, 1'b0);
        step(1'b1, 1'b1, 7'd99, 7'd98, 1'b1, 1'b0);
        check("r036_drops", 32'(drops_o), 32'd3);
        check("r036_level", 32'(level_o), 32'd3);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 7'd0, 7'd0, 1'b1, 1'b0);

        // Reset mid-frame: two delivered, one stored, then reset
        step(1'b0, 1'b0, 7'd0, 7'd0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 7'(i + 60), 7'(i + 70), 1'b0, 1'b0);
        step(1'b0, 1'b0, 7'd0, 7'd0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 7'd0, 7'd0, 1'b1, 1'b0);
        check("r037_pre_level", 32'(level_o), 32'd1);
        step(1'b1, 1'b1, 7'd5, 7'd6, 1'b1, 1'b1);
        check("r037_valid", 32'(m_tvalid), 32'd0);
        check("r037_level", 32'(level_o), 32'd0);
        check("r037_tlast_cleared", 32'(m_tlast), 32'd0);
        step(1'b1, 1'b1, 7'd11, 7'd12, 1'b0, 1'b0);
        check("r037_new_valid", 32'(m_tvalid), 32'd1);
        check("r037_new_tlast", 32'(m_tlast), 32'd0);
        check("r037_new_data", 32'(m_tdata), 32'({7'd12, 7'd11}));
        step(1'b0, 1'b0, 7'd0, 7'd0, 1'b1, 1'b0);

        // Randomized traffic kept below the overflow point
        step(1'b0, 1'b0, 7'd0, 7'd0, 1'b0, 1'b1);
        written = 0;
        cyc     = 0;
        while (written < 1000 && cyc < 20000) begin
            v = ($urandom_range(0, 1) == 1) && (q_m.size() < DEPTH);
            l = v ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) == 1);
            r = ($urandom_range(0, 3) != 0);
            if (v && l) written++;
            step(v, l, 7'($urandom), 7'($urandom), r, 1'b0);
            cyc++;
        end
        check("r035_budget", 32'(written), 32'd1000);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 7'd0, 7'd0, 1'b1, 1'b0);
        check("r035_drops", 32'(drops_o), 32'd0);
        check("r035_drained", 32'(level_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
